fixed_word_serializer: RTL and testbench



---
 rtl/fixed_word_serializer_if.sv | 26 ++
 rtl/fixed_word_serializer.sv | 95 +++++++++
 tb/tb_fixed_word_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_word_serializer_if.sv
// Frame-in / word-out handshake bundle for the fixed-word serializer.
// The serializer uses master; the producer/consumer environment uses slave.
interface fixed_word_serializer_if #(
  parameter int WIDTH     = 32,
  parameter int TRI_WORDS = 9
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_kind;
  logic [TRI_WORDS*WIDTH-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic [3:0]                   out_index;

  modport master (
    input  in_valid, in_kind, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_index
  );

  modport slave (
    output in_valid, in_kind, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_index
  );
endinterface

// File: rtl/fixed_word_serializer.sv
// Serializes a packed ray (6 words) or triangle (9 words) MSB-first, first word 1 cycle after accept.
// Words hold under out_ready=0; a new frame loads on the last handshake for zero-bubble streaming.
module fixed_word_serializer #(
  parameter int WIDTH     = 32,
  parameter int RAY_WORDS = 6,
  parameter int TRI_WORDS = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  fixed_word_serializer_if.master   bus,
  output logic [15:0]               frames_sent
);
  localparam int FRAME_BITS = TRI_WORDS * WIDTH;
  localparam int RAY_BITS   = RAY_WORDS * WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [3:0]              idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    kind_q, kind_d;
  logic [15:0]             frames_q, frames_d;

  logic                    out_valid;
  logic                    hs;
  logic                    in_ready;
  logic                    accept;
  logic [3:0]              len_m1;
  logic [3:0]              idx_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      kind_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      kind_q   <= kind_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    last_d   = last_q;
    kind_d   = kind_q;
    frames_d = frames_q;

    out_valid = (state_q == SEND);
    hs        = out_valid && bus.out_ready;
    in_ready  = (state_q == IDLE) || (hs && last_q);
    accept    = bus.in_valid && in_ready;
    len_m1    = kind_q ? 4'(TRI_WORDS - 1) : 4'(RAY_WORDS - 1);
    idx_nxt   = idx_q + 4'd1;

    if (hs) begin
      if (last_q) begin
        frames_d = frames_q + 16'd1;
        state_d  = IDLE;
      end else begin
        sh_d   = sh_q << WIDTH;
        idx_d  = idx_nxt;
        last_d = (idx_nxt == len_m1);
      end
    end

    // A new frame overrides the drain-to-IDLE decision of the same cycle.
    if (accept) begin
      state_d = SEND;
      kind_d  = bus.in_kind;
      idx_d   = '0;
      last_d  = 1'b0;
      if (bus.in_kind)
        sh_d = bus.in_data;
      else
        sh_d = {bus.in_data[RAY_BITS-1:0], {(FRAME_BITS-RAY_BITS){1'b0}}};
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = sh_q[FRAME_BITS-1 -: WIDTH];
  assign bus.out_index = idx_q;
  assign bus.out_last  = last_q;
  assign frames_sent   = frames_q;
endmodule

// File: tb/tb_fixed_word_serializer.sv
// Directed plus randomized bench for fixed_word_serializer against a frame-queue reference model.
module tb_fixed_word_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] frames_sent;

  fixed_word_serializer_if #(.WIDTH(32), .TRI_WORDS(9)) bus ();

  fixed_word_serializer #(.WIDTH(32), .RAY_WORDS(6), .TRI_WORDS(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          idx;
    bit          last;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cur_words[9];
  bit          cur_kind;
  logic [15:0] frames_exp = 16'd0;
  int          words_seen = 0;
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;
  int          pat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consumer ready generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (pat % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      pat++;
    end
  end

  // Reference model: a frame in flight is a queue of expected words; handshakes pop it.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      frames_exp = 16'd0;
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, (q.size() == 0) || (bus.out_ready && q[0].last)});
      chk("frames_sent", {16'd0, frames_sent}, {16'd0, frames_exp});
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].w);
        chk("out_index", {28'd0, bus.out_index}, 32'(q[0].idx));
        chk("out_last", {31'd0, bus.out_last}, {31'd0, q[0].last});
        if (bus.out_ready) begin
          if (q[0].last) frames_exp = frames_exp + 16'd1;
          void'(q.pop_front());
          words_seen++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < (cur_kind ? 9 : 6); i++) begin
          exp_t e;
          e.w    = cur_words[i];
          e.idx  = i;
          e.last = (i == (cur_kind ? 8 : 5));
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input bit kind, input bit ones_upper);
    int len;
    bit accepted;
    len = kind ? 9 : 6;
    cur_kind = kind;
    bus.in_kind = kind;
    bus.in_data = ones_upper ? '1 : {9{32'hA5A5_5A5A}};
    for (int i = 0; i < len; i++)
      bus.in_data[(len-1-i)*32 +: 32] = cur_words[i];
    bus.in_valid = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    chk("accept", {31'd0, accepted}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_kind  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 9; i++) bus.in_data[i*32 +: 32] = $urandom;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    @(negedge clk);
    chk("drained", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ray(input logic [31:0] a, b, c, d, e, f);
    cur_words[0] = a; cur_words[1] = b; cur_words[2] = c;
    cur_words[3] = d; cur_words[4] = e; cur_words[5] = f;
  endtask

  task automatic set_tri();
    cur_words[0] = 32'hF6986DB0; cur_words[1] = 32'h0CF1BBD0; cur_words[2] = 32'h00000000;
    cur_words[3] = 32'h00000000; cur_words[4] = 32'h10000000; cur_words[5] = 32'h00000000;
    cur_words[6] = 32'hFB93ED50; cur_words[7] = 32'h0D9C38B0; cur_words[8] = 32'hF8D83518;
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_kind  = 1'b0;
    bus.in_data  = '0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_out_index", {28'd0, bus.out_index}, 32'd0);
    chk("rst_frames", {16'd0, frames_sent}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ray, always ready
    set_ray(32'h10000000, 32'h08000000, 32'hF8000000, 32'hF977D0F0, 32'h0D105F30, 32'hF977D0F0);
    send(1'b0, 1'b0);
    drain();
    chk("ray_frames", {16'd0, frames_sent}, 32'd1);

    // Triangle under 1,0,0 backpressure
    ready_mode = 1;
    pat = 0;
    set_tri();
    send(1'b1, 1'b0);
    drain();
    chk("tri_frames", {16'd0, frames_sent}, 32'd2);

    // Back-to-back ray then triangle
    ready_mode = 0;
    base = words_seen;
    set_ray(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666);
    send(1'b0, 1'b0);
    set_tri();
    send(1'b1, 1'b0);
    drain();
    chk("b2b_words", 32'(words_seen - base), 32'd15);
    chk("b2b_frames", {16'd0, frames_sent}, 32'd4);

    // Reset after word 2 of a triangle
    set_tri();
    send(1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (q.size() == 6) break;
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_frames", {16'd0, frames_sent}, 32'd0);
    @(posedge clk);
    #1;
    set_ray(32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0);
    send(1'b0, 1'b0);
    drain();
    chk("post_rst_frames", {16'd0, frames_sent}, 32'd1);

    // Counter wrap
    force dut.frames_q = 16'hFFFF;
    #1;
    release dut.frames_q;
    frames_exp = 16'hFFFF;
    set_ray(32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF);
    send(1'b0, 1'b0);
    drain();
    chk("wrap_frames", {16'd0, frames_sent}, 32'd0);

    // Ray with all-ones upper bits
    set_ray(32'h10000000, 32'h08000000, 32'hF8000000, 32'hF977D0F0, 32'h0D105F30, 32'hF977D0F0);
    send(1'b0, 1'b1);
    drain();

    // Random frames under random backpressure
    ready_mode = 2;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 9; i++) cur_words[i] = $urandom;
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    chk("rand_frames", {16'd0, frames_sent}, {16'd0, frames_exp});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
